simple_bus_fabric: RTL and testbench
====================================

// Module: simple_bus_fabric
// PURPOSE
//  Parametrised single-master, multi-slave simple-bus interconnect; successor to the wired-OR shared bus.
//  Decodes the word address into fixed-size chunks and selects one of NUM_SLAVES slaves one-hot.
//  Adds a per-slave ack handshake, registered read-data mux, unmapped-address and timeout bus errors, and error capture.
//  Sits between the CPU data-bus master port and all data-bus peripherals (DRam, UART, future blocks).
// PARAMETERS
//  WORD_ADDR_WIDTH      16  word address width of master bus
//  ADDR_BITS_PER_CHUNK   6  low address bits forwarded to slaves; chunk = 2^6 words
//  NUM_SLAVES            4  number of slave ports; slave k owns chunk index k
//  TIMEOUT_CYCLES       16  ACCESS cycles allowed before bus-error timeout (>=1)
//  ERR_CNT_WIDTH         8  width of saturating error counter
// PORTS
//  i_Clk         in   1                      clock, all state on rising edge
//  i_Rst         in   1                      asynchronous, active-low reset
//  i_M_Req       in   1                      master request pulse, sampled only in IDLE
//  i_M_Addr      in   WORD_ADDR_WIDTH        master word address
//  i_M_WE        in   1                      1 = write, 0 = read
//  i_M_ByteEn    in   4                      byte enables
//  i_M_WD        in   32                     write data
//  o_M_RD        out  32                     read data, valid while o_M_Ack=1
//  o_M_Ack       out  1                      one-cycle completion pulse
//  o_M_Err       out  1                      qualifies o_M_Ack: transfer failed
//  o_M_Busy      out  1                      1 whenever state != IDLE
//  o_S_Sel       out  NUM_SLAVES             one-hot slave select, ACCESS only
//  o_S_Addr      out  ADDR_BITS_PER_CHUNK    in-chunk word address
//  o_S_WE        out  1                      write strobe, qualified by o_S_Sel
//  o_S_ByteEn    out  4                      byte enables to slaves
//  o_S_WD        out  32                     write data to slaves
//  i_S_RD        in   NUM_SLAVES*32          slave read data; slave k at [32k+31:32k]
//  i_S_Ack       in   NUM_SLAVES             slave k completes current access
//  i_Err_Clr     in   1                      synchronous clear of error counter
//  o_Err_Addr    out  WORD_ADDR_WIDTH        address of most recent failed transfer
//  o_Err_Cnt     out  ERR_CNT_WIDTH          saturating count of failed transfers
// BEHAVIOUR
//  - Reset (i_Rst=0, asynchronous): state IDLE; every output 0; timeout counter and captured request regs 0.
//  - Decode: idx = i_M_Addr[WORD_ADDR_WIDTH-1:ADDR_BITS_PER_CHUNK]; idx < NUM_SLAVES is mapped, else unmapped.
//  - FSM: IDLE, ACCESS, RESP.
//  - IDLE, i_M_Req=1: capture addr/WE/ByteEn/WD/idx into regs.
//    - Mapped: go to ACCESS, clear timeout counter.
//    - Unmapped: go straight to RESP with error set.
//  - ACCESS: o_S_Sel[idx]=1; o_S_Addr/WE/ByteEn/WD driven from captured regs, stable for the whole state.
//    - i_S_Ack[idx]=1: latch i_S_RD[idx] (forced to 0 for writes) into o_M_RD; go to RESP, error clear.
//    - Otherwise counter++; once TIMEOUT_CYCLES cycles pass with no ack: go to RESP, error set, o_M_RD=0.
//    - i_S_Ack from non-selected slaves is ignored.
//  - RESP: o_M_Ack=1 and o_M_Err=error flag, for exactly one cycle; go to IDLE. o_S_Sel=0.
//  - Latency, req cycle N: mapped with immediate ack -> o_M_Ack at N+2; unmapped -> N+1; timeout -> N+1+TIMEOUT_CYCLES.
//  - i_M_Req while o_M_Busy=1 is ignored, not queued. Back-to-back: next req is accepted in the cycle after RESP.
//  - o_M_RD holds its value until the next completion. o_M_Ack and o_M_Err are 0 outside RESP.
//  - On entry to RESP with error: o_Err_Addr <= captured address; o_Err_Cnt increments, saturating at all-ones.
//  - i_Err_Clr clears o_Err_Cnt only. If a new error lands in the same cycle, o_Err_Cnt=1 (clear first, then count).
//  - Reset asserted mid-transfer: immediate IDLE, o_S_Sel=0, and no ack is ever issued for that transfer.
// TESTING
//  - Read slave 0 addr 0x0005, slave acks in first ACCESS cycle with 0xDEADBEEF ->
//    o_S_Sel=4'b0001, o_S_Addr=5, o_M_Ack at req+2, o_M_RD=0xDEADBEEF, o_M_Err=0.
//  - Write slave 1 addr 0x0047, ByteEn 4'b0011, WD 0x12345678, ack after 3 cycles ->
//    o_S_Sel=4'b0010 held 3 cycles, o_S_WE=1, o_M_Ack at req+4, o_M_RD=0.
//  - Read addr 0x0100 (idx 4, NUM_SLAVES=4) -> o_S_Sel never asserted, o_M_Ack+o_M_Err at req+1,
//    o_Err_Addr=0x0100, o_Err_Cnt=1.
//  - Read slave 2, no ack -> o_M_Ack+o_M_Err at req+17, o_M_RD=0; slave 3 acking during the access has no effect.
//  - 300 unmapped reads -> o_Err_Cnt stops at 255; i_Err_Clr coincident with an error -> o_Err_Cnt=1.
//  - Assert i_Rst low mid-ACCESS, also a second req while busy ->
//    outputs 0 asynchronously, no o_M_Ack afterwards, ignored req produces no transfer.

Source files
------------

// File: rtl/simple_bus_fabric.sv
// Single-master, multi-slave simple-bus interconnect with one-hot chunk decode,
// per-slave ack, registered read data, unmapped/timeout errors and error capture.
//
// Ports:
//   i_Clk, i_Rst                      clock, async active-low reset
//   i_M_Req/Addr/WE/ByteEn/WD         master request (sampled only in IDLE)
//   o_M_RD/Ack/Err/Busy               master response and status
//   o_S_Sel/Addr/WE/ByteEn/WD         slave-side request, Sel one-hot in ACCESS
//   i_S_RD, i_S_Ack                   packed slave read data and acks
//   i_Err_Clr                         clear of the error counter
//   o_Err_Addr, o_Err_Cnt             last failed address, saturating fail count
module simple_bus_fabric #(
    parameter int WORD_ADDR_WIDTH     = 16,
    parameter int ADDR_BITS_PER_CHUNK = 6,
    parameter int NUM_SLAVES          = 4,
    parameter int TIMEOUT_CYCLES      = 16,
    parameter int ERR_CNT_WIDTH       = 8
) (
    input  logic                           i_Clk,
    input  logic                           i_Rst,
    input  logic                           i_M_Req,
    input  logic [WORD_ADDR_WIDTH-1:0]     i_M_Addr,
    input  logic                           i_M_WE,
    input  logic [3:0]                     i_M_ByteEn,
    input  logic [31:0]                    i_M_WD,
    output logic [31:0]                    o_M_RD,
    output logic                           o_M_Ack,
    output logic                           o_M_Err,
    output logic                           o_M_Busy,
    output logic [NUM_SLAVES-1:0]          o_S_Sel,
    output logic [ADDR_BITS_PER_CHUNK-1:0] o_S_Addr,
    output logic                           o_S_WE,
    output logic [3:0]                     o_S_ByteEn,
    output logic [31:0]                    o_S_WD,
    input  logic [NUM_SLAVES*32-1:0]       i_S_RD,
    input  logic [NUM_SLAVES-1:0]          i_S_Ack,
    input  logic                           i_Err_Clr,
    output logic [WORD_ADDR_WIDTH-1:0]     o_Err_Addr,
    output logic [ERR_CNT_WIDTH-1:0]       o_Err_Cnt
);

    localparam int IDX_W = WORD_ADDR_WIDTH - ADDR_BITS_PER_CHUNK;
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [ERR_CNT_WIDTH-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t state, state_nxt;

    logic [WORD_ADDR_WIDTH-1:0] req_addr;
    logic                       req_we;
    logic [3:0]                 req_be;
    logic [31:0]                req_wd;
    logic [IDX_W-1:0]           req_idx;
    logic [TMO_W-1:0]           tmo_cnt;
    logic                       err_flag;

    logic [IDX_W-1:0]      m_idx;
    logic                  m_mapped;
    logic [NUM_SLAVES-1:0] sel;
    logic [31:0]           sel_rd;
    logic                  sel_ack;
    logic                  timeout;
    logic                  new_err;

    assign m_idx    = i_M_Addr[WORD_ADDR_WIDTH-1:ADDR_BITS_PER_CHUNK];
    assign m_mapped = m_idx < IDX_W'(NUM_SLAVES);

    // Decode of the captured index; the loop keeps the mux in range
    // even though req_idx is wider than the slave count.
    always_comb begin
        sel    = '0;
        sel_rd = '0;
        for (int k = 0; k < NUM_SLAVES; k++) begin
            if (req_idx == IDX_W'(k)) begin
                sel[k] = 1'b1;
                sel_rd = i_S_RD[32*k +: 32];
            end
        end
    end

    // Acks from slaves other than the addressed one never count.
    assign sel_ack = |(sel & i_S_Ack);
    assign timeout = tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1);

    assign new_err = ((state == IDLE) && i_M_Req && !m_mapped) ||
                     ((state == ACCESS) && !sel_ack && timeout);

    always_ff @(posedge i_Clk or negedge i_Rst) begin
        if (!i_Rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (i_M_Req) begin
                    state_nxt = m_mapped ? ACCESS : RESP;
                end
            end
            ACCESS: begin
                if (sel_ack || timeout) begin
                    state_nxt = RESP;
                end
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        o_M_Ack  = state == RESP;
        o_M_Err  = (state == RESP) && err_flag;
        o_M_Busy = state != IDLE;
        o_S_Sel  = (state == ACCESS) ? sel : '0;
    end

    assign o_S_Addr   = req_addr[ADDR_BITS_PER_CHUNK-1:0];
    assign o_S_WE     = req_we;
    assign o_S_ByteEn = req_be;
    assign o_S_WD     = req_wd;

    always_ff @(posedge i_Clk or negedge i_Rst) begin
        if (!i_Rst) begin
            req_addr <= '0;
            req_we   <= 1'b0;
            req_be   <= '0;
            req_wd   <= '0;
            req_idx  <= '0;
            tmo_cnt  <= '0;
            err_flag <= 1'b0;
            o_M_RD   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (i_M_Req) begin
                        req_addr <= i_M_Addr;
                        req_we   <= i_M_WE;
                        req_be   <= i_M_ByteEn;
                        req_wd   <= i_M_WD;
                        req_idx  <= m_idx;
                        tmo_cnt  <= '0;
                        err_flag <= !m_mapped;
                        if (!m_mapped) begin
                            o_M_RD <= '0;
                        end
                    end
                end
                ACCESS: begin
                    if (sel_ack) begin
                        o_M_RD   <= req_we ? 32'h0 : sel_rd;
                        err_flag <= 1'b0;
                    end else if (timeout) begin
                        o_M_RD   <= '0;
                        err_flag <= 1'b1;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Clear wins first, then a same-cycle error counts from zero.
    always_ff @(posedge i_Clk or negedge i_Rst) begin
        if (!i_Rst) begin
            o_Err_Addr <= '0;
            o_Err_Cnt  <= '0;
        end else begin
            if (new_err) begin
                o_Err_Addr <= (state == IDLE) ? i_M_Addr : req_addr;
            end
            if (i_Err_Clr) begin
                o_Err_Cnt <= new_err ? ERR_CNT_WIDTH'(1) : '0;
            end else if (new_err && (o_Err_Cnt != CNT_MAX)) begin
                o_Err_Cnt <= o_Err_Cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_simple_bus_fabric.sv
// Self-checking bench for simple_bus_fabric: spec vectors, randomized
// transactions against a transaction-level model, and reset/busy corners.
module tb_simple_bus_fabric;

    localparam int AW = 16;
    localparam int CB = 6;
    localparam int NS = 4;
    localparam int TO = 16;
    localparam int EW = 8;

    logic             clk;
    logic             rst_n;
    logic             m_req;
    logic [AW-1:0]    m_addr;
    logic             m_we;
    logic [3:0]       m_be;
    logic [31:0]      m_wd;
    logic [31:0]      m_rd;
    logic             m_ack;
    logic             m_err;
    logic             m_busy;
    logic [NS-1:0]    s_sel;
    logic [CB-1:0]    s_addr;
    logic             s_we;
    logic [3:0]       s_be;
    logic [31:0]      s_wd;
    logic [NS*32-1:0] s_rd_bus;
    logic [NS-1:0]    s_ack;
    logic             err_clr;
    logic [AW-1:0]    err_addr;
    logic [EW-1:0]    err_cnt;

    logic [31:0] slave_rd [NS];

    int    checks = 0;
    int    errors = 0;
    int    exp_cnt = 0;
    logic [AW-1:0] exp_eaddr = '0;
    string cur_tag = "init";

    simple_bus_fabric #(
        .WORD_ADDR_WIDTH(AW), .ADDR_BITS_PER_CHUNK(CB), .NUM_SLAVES(NS),
        .TIMEOUT_CYCLES(TO), .ERR_CNT_WIDTH(EW)
    ) dut (
        .i_Clk(clk), .i_Rst(rst_n),
        .i_M_Req(m_req), .i_M_Addr(m_addr), .i_M_WE(m_we),
        .i_M_ByteEn(m_be), .i_M_WD(m_wd),
        .o_M_RD(m_rd), .o_M_Ack(m_ack), .o_M_Err(m_err), .o_M_Busy(m_busy),
        .o_S_Sel(s_sel), .o_S_Addr(s_addr), .o_S_WE(s_we),
        .o_S_ByteEn(s_be), .o_S_WD(s_wd),
        .i_S_RD(s_rd_bus), .i_S_Ack(s_ack),
        .i_Err_Clr(err_clr), .o_Err_Addr(err_addr), .o_Err_Cnt(err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        s_rd_bus = '0;
        for (int k = 0; k < NS; k++) s_rd_bus[32*k +: 32] = slave_rd[k];
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not end");
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s/%s: got 0x%0h, expected 0x%0h",
                     cur_tag, name, act, exp);
        end
    endtask

    typedef struct packed {
        int          lat;
        logic        err;
        logic [31:0] rd;
        logic        chk_rd;
        logic [3:0]  sel;
    } pred_t;

    // Transaction-level prediction straight from the bus rules.
    function automatic pred_t predict(input logic [AW-1:0] addr,
                                      input logic we, input int dly);
        pred_t p;
        int idx;
        idx = int'(addr) / (1 << CB);
        p.sel = '0;
        p.rd = '0;
        p.chk_rd = 1'b1;
        if (idx >= NS) begin
            p.lat = 1;
            p.err = 1'b1;
            p.chk_rd = 1'b0;
        end else begin
            p.sel = 4'(1 << idx);
            if (dly >= 0 && dly < TO) begin
                p.lat = dly + 2;
                p.err = 1'b0;
                p.rd = we ? 32'h0 : slave_rd[idx];
            end else begin
                p.lat = TO + 1;
                p.err = 1'b1;
            end
        end
        return p;
    endfunction

    task automatic run_txn(input logic [AW-1:0] addr, input logic we,
                           input logic [3:0] be, input logic [31:0] wd,
                           input int dly, input int noise, input bit clr,
                           input bit busy_req,
                           output int o_lat, output logic o_err,
                           output logic [31:0] o_rd, output int o_acc,
                           output logic [3:0] o_selor);
        pred_t p;
        int cyc;
        int acc;
        bit got;
        bit sel_bad;
        bit drv_bad;
        p = predict(addr, we, dly);
        o_lat = 0; o_err = 1'b0; o_rd = '0; o_selor = '0;
        @(negedge clk);
        m_req = 1'b1; m_addr = addr; m_we = we; m_be = be; m_wd = wd;
        err_clr = clr;
        @(negedge clk);
        m_req = 1'b0; err_clr = 1'b0;
        cyc = 1; acc = 0; got = 1'b0; sel_bad = 1'b0; drv_bad = 1'b0;
        while (!got && cyc <= 60) begin
            s_ack = '0;
            if (m_ack) begin
                got = 1'b1;
                o_lat = cyc;
            end else begin
                if (s_sel != '0) begin
                    o_selor = o_selor | s_sel;
                    if (s_sel != p.sel) sel_bad = 1'b1;
                    if (s_addr != addr[CB-1:0] || s_we != we ||
                        s_be != be || s_wd != wd) drv_bad = 1'b1;
                    if (dly >= 0 && acc == dly && (s_sel & p.sel) != '0)
                        s_ack = p.sel;
                    acc++;
                end
                if (noise >= 0) s_ack = s_ack | 4'(1 << noise);
                if (busy_req && cyc == 1) begin
                    m_req = 1'b1; m_addr = 16'h0300;
                end else begin
                    m_req = 1'b0; m_addr = addr;
                end
                @(negedge clk);
                cyc++;
            end
        end
        s_ack = '0; m_req = 1'b0; m_addr = addr;
        o_acc = acc;
        if (clr) exp_cnt = 0;
        if (p.err) begin
            exp_cnt = (exp_cnt < 255) ? exp_cnt + 1 : 255;
            exp_eaddr = addr;
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL %s/ack: no o_M_Ack within 60 cycles, expected at %0d",
                     cur_tag, p.lat);
        end else begin
            o_err = m_err;
            o_rd = m_rd;
            check("latency", 64'(o_lat), 64'(p.lat));
            check("m_err", 64'(m_err), 64'(p.err));
            if (p.chk_rd) check("m_rd", 64'(m_rd), 64'(p.rd));
            check("sel_cycles", 64'(acc), 64'(p.sel != 0 ? p.lat - 1 : 0));
            check("sel_bad", 64'(sel_bad), 64'(0));
            check("slave_drive", 64'(drv_bad), 64'(0));
            check("err_cnt", 64'(err_cnt), 64'(exp_cnt));
            check("err_addr", 64'(err_addr), 64'(exp_eaddr));
            @(negedge clk);
            check("ack_pulse", 64'({m_ack, m_err, m_busy}), 64'(0));
            if (p.chk_rd) check("rd_hold", 64'(m_rd), 64'(p.rd));
        end
    endtask

    typedef struct packed {
        logic [AW-1:0] addr;
        logic          we;
        logic [3:0]    be;
        logic [31:0]   wd;
        int            dly;
        int            noise;
        logic [31:0]   rdat;
        int            lat;
        logic          err;
        logic          chk_rd;
        logic [31:0]   rd;
        logic [3:0]    sel;
        int            acc;
    } vec_t;

    vec_t tbl [6];

    int          r_lat;
    logic        r_err;
    logic [31:0] r_rd;
    int          r_acc;
    logic [3:0]  r_sel;

    initial begin
        logic [AW-1:0] a;
        logic [9:0]    ix;
        int            d;
        int            nz;
        int            tgt;
        bit            saw;

        tbl[0] = '{16'h0005, 1'b0, 4'hF, 32'h0, 0, -1, 32'hDEADBEEF,
                   2, 1'b0, 1'b1, 32'hDEADBEEF, 4'b0001, 1};
        tbl[1] = '{16'h0047, 1'b1, 4'b0011, 32'h12345678, 2, -1, 32'hCAFEF00D,
                   4, 1'b0, 1'b1, 32'h0, 4'b0010, 3};
        tbl[2] = '{16'h0100, 1'b0, 4'hF, 32'h0, 0, -1, 32'h11112222,
                   1, 1'b1, 1'b0, 32'h0, 4'b0000, 0};
        tbl[3] = '{16'h0085, 1'b0, 4'hF, 32'h0, -1, 3, 32'h33334444,
                   17, 1'b1, 1'b1, 32'h0, 4'b0100, 16};
        tbl[4] = '{16'h00C0, 1'b0, 4'hC, 32'h0, 1, 0, 32'hA5A55A5A,
                   3, 1'b0, 1'b1, 32'hA5A55A5A, 4'b1000, 2};
        tbl[5] = '{16'hFFFF, 1'b1, 4'h1, 32'h55, 0, -1, 32'h0,
                   1, 1'b1, 1'b0, 32'h0, 4'b0000, 0};

        rst_n = 1'b1; m_req = 1'b0; m_addr = '0; m_we = 1'b0;
        m_be = '0; m_wd = '0; s_ack = '0; err_clr = 1'b0;
        for (int k = 0; k < NS; k++) slave_rd[k] = 32'h0;

        cur_tag = "reset";
        #1 rst_n = 1'b0;
        #3;
        check("busy_ack_err", 64'({m_busy, m_ack, m_err}), 64'(0));
        check("s_sel", 64'(s_sel), 64'(0));
        check("m_rd", 64'(m_rd), 64'(0));
        check("slave_side", 64'({s_addr, s_we, s_be, s_wd}), 64'(0));
        check("err_regs", 64'({err_addr, err_cnt}), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            cur_tag = $sformatf("vec%0d", i);
            tgt = int'(tbl[i].addr) / (1 << CB);
            for (int k = 0; k < NS; k++)
                slave_rd[k] = (k == tgt) ? tbl[i].rdat
                                         : tbl[i].rdat ^ (32'h01010101 * (k + 1));
            run_txn(tbl[i].addr, tbl[i].we, tbl[i].be, tbl[i].wd,
                    tbl[i].dly, tbl[i].noise, 1'b0, 1'b0,
                    r_lat, r_err, r_rd, r_acc, r_sel);
            check("tbl_lat", 64'(r_lat), 64'(tbl[i].lat));
            check("tbl_err", 64'(r_err), 64'(tbl[i].err));
            if (tbl[i].chk_rd) check("tbl_rd", 64'(r_rd), 64'(tbl[i].rd));
            check("tbl_sel", 64'(r_sel), 64'(tbl[i].sel));
            check("tbl_acc", 64'(r_acc), 64'(tbl[i].acc));
        end

        cur_tag = "busy_req";
        for (int k = 0; k < NS; k++) slave_rd[k] = 32'h900D0000 + k;
        run_txn(16'h0042, 1'b0, 4'hF, 32'h0, 3, -1, 1'b0, 1'b1,
                r_lat, r_err, r_rd, r_acc, r_sel);
        saw = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (m_ack || m_busy) saw = 1'b1;
            @(negedge clk);
        end
        check("no_extra_xfer", 64'(saw), 64'(0));
        check("err_cnt_after", 64'(err_cnt), 64'(exp_cnt));

        for (int i = 0; i < 40; i++) begin
            cur_tag = $sformatf("rand%0d", i);
            ix = ($urandom % 4 == 0) ? 10'($urandom_range(4, 1023))
                                     : 10'($urandom_range(0, 3));
            a = {ix, 6'($urandom)};
            d = int'($urandom % 8);
            if (d == 0) d = -1;
            else if (d == 1) d = 20;
            else d = int'($urandom_range(0, 4));
            nz = -1;
            if ($urandom % 2 == 1)
                nz = (ix < 4) ? (int'(ix) + 1) % NS : int'($urandom % NS);
            for (int k = 0; k < NS; k++) slave_rd[k] = $urandom;
            run_txn(a, 1'($urandom), 4'($urandom), $urandom, d, nz,
                    ($urandom % 10 == 0), 1'b0,
                    r_lat, r_err, r_rd, r_acc, r_sel);
        end

        cur_tag = "saturate";
        for (int i = 0; i < 300; i++) begin
            a = {10'($urandom_range(4, 1023)), 6'($urandom)};
            run_txn(a, 1'b0, 4'hF, 32'h0, 0, -1, 1'b0, 1'b0,
                    r_lat, r_err, r_rd, r_acc, r_sel);
        end
        check("cnt_saturated", 64'(err_cnt), 64'(255));

        cur_tag = "clr_with_err";
        run_txn(16'h0123, 1'b0, 4'hF, 32'h0, 0, -1, 1'b1, 1'b0,
                r_lat, r_err, r_rd, r_acc, r_sel);
        check("cnt_is_one", 64'(err_cnt), 64'(1));

        cur_tag = "clr_alone";
        @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        exp_cnt = 0;
        check("cnt_cleared", 64'(err_cnt), 64'(0));
        check("eaddr_kept", 64'(err_addr), 64'(exp_eaddr));

        cur_tag = "rst_mid";
        for (int k = 0; k < NS; k++) slave_rd[k] = 32'hBAD00000 + k;
        @(negedge clk);
        m_req = 1'b1; m_addr = 16'h00C3; m_we = 1'b0;
        @(negedge clk);
        m_req = 1'b0;
        repeat (3) @(negedge clk);
        check("busy_before", 64'(m_busy), 64'(1));
        check("sel_before", 64'(s_sel), 64'(4'b1000));
        #2 rst_n = 1'b0;
        #1;
        check("busy_sel_async", 64'({m_busy, s_sel}), 64'(0));
        check("ack_async", 64'({m_ack, m_err}), 64'(0));
        check("regs_async", 64'({m_rd, err_cnt}), 64'(0));
        exp_cnt = 0;
        exp_eaddr = '0;
        @(negedge clk);
        rst_n = 1'b1;
        saw = 1'b0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (m_ack || m_busy || s_sel != '0) saw = 1'b1;
        end
        check("no_ack_after_rst", 64'(saw), 64'(0));

        cur_tag = "post_rst";
        for (int k = 0; k < NS; k++) slave_rd[k] = 32'h7E570000 + k;
        run_txn(16'h0081, 1'b0, 4'hF, 32'h0, 0, -1, 1'b0, 1'b0,
                r_lat, r_err, r_rd, r_acc, r_sel);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
